// File: rtl/mac_seq_4_bit_if.sv
// Operand/command and result bundle for the sequential MAC; the master issues commands, the slave is the MAC.
interface mac_seq_4_bit_if #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8
);
  logic             start;
  logic             clear;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc;
  logic             overflow;

  modport master (
    output start, clear, a, b,
    input  busy, done, acc, overflow
  );

  modport slave (
    input  start, clear, a, b,
    output busy, done, acc, overflow
  );
endinterface

// File: rtl/mac_seq_4_bit.sv
// Shift-and-add multiply (one partial product per clock) accumulated into a wrapping acc with sticky overflow.
// Latency IN_W+2 edges from start to done; start/clear are only sampled in IDLE and are dropped while busy.
module mac_seq_4_bit #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_4_bit_if.slave bus
);
  localparam int PP_W  = 2 * IN_W;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IN_W-1:0]  a_r;
  logic [IN_W-1:0]  b_r;
  logic [PP_W-1:0]  pp;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             done_r;
  logic             busy_r;

  logic             load;
  logic             step;
  logic             accum;
  logic             do_clear;
  logic [PP_W-1:0]  a_ext;
  logic [PP_W-1:0]  partial;
  logic [ACC_W:0]   sum;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    accum     = 1'b0;
    do_clear  = 1'b0;
    case (state)
      IDLE: begin
        do_clear = bus.clear;
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = MULT;
        end
      end
      MULT: begin
        step = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ACC;
      end
      ACC: begin
        accum     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_ext   = PP_W'(a_r);
    partial = b_r[cnt] ? (a_ext << cnt) : '0;
    sum     = {1'b0, acc_r} + (ACC_W + 1)'(pp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      pp     <= '0;
      cnt    <= '0;
      acc_r  <= '0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= accum;
      busy_r <= (state_nxt != IDLE);
      if (load) begin
        a_r <= bus.a;
        b_r <= bus.b;
        pp  <= '0;
        cnt <= '0;
      end
      if (step) begin
        pp  <= pp + partial;
        cnt <= cnt + CNT_W'(1);
      end
      // clear and start on one edge: clear lands now, the accumulate happens IN_W+1 edges later onto 0
      if (do_clear) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
      end
      if (accum) begin
        acc_r <= sum[ACC_W-1:0];
        ovf_r <= ovf_r | sum[ACC_W];
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.acc      = acc_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_mac_seq_4_bit.sv
// Self-checking bench for mac_seq_4_bit: directed vector table, hand-written corner sequences, exhaustive and random runs.
module tb_mac_seq_4_bit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  mac_seq_4_bit_if #(.IN_W(4), .ACC_W(8)) bus ();

  mac_seq_4_bit #(.IN_W(4), .ACC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] acc;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Issues one operation from a negedge; returns at the negedge of the done cycle (or after a timeout).
  task automatic run_op(input logic clr, input logic [3:0] av, input logic [3:0] bv,
                        output int r_acc, output int r_ovf, output int r_busy,
                        output int r_done_n, output int r_busy_at_done, output int r_cyc);
    bus.start = 1'b1;
    bus.clear = clr;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
    r_busy    = 0;
    r_done_n  = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.done) begin
        r_done_n = n;
        break;
      end
      if (bus.busy) r_busy++;
    end
    r_acc          = int'(bus.acc);
    r_ovf          = int'(bus.overflow);
    r_busy_at_done = int'(bus.busy);
    r_cyc          = cyc;
  endtask

  initial begin
    vec_t tbl[5];
    int   g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc, last_cyc, dones;
    int   acc_m, ovf_m, s;
    logic rclr;
    logic [3:0] ra, rb;

    checks = 0;
    errors = 0;
    tbl[0] = '{1'b0, 4'd15, 4'd15, 8'd225, 1'b0};
    tbl[1] = '{1'b0, 4'd3,  4'd2,  8'd231, 1'b0};
    tbl[2] = '{1'b0, 4'd5,  4'd5,  8'd0,   1'b1};
    tbl[3] = '{1'b0, 4'd1,  4'd1,  8'd1,   1'b1};
    tbl[4] = '{1'b1, 4'd7,  4'd9,  8'd63,  1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_acc",  int'(bus.acc), 0);
    chk("reset_ovf",  int'(bus.overflow), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed sequence: latency, busy window, single done pulse, wrap and sticky overflow.
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].clr, tbl[i].a, tbl[i].b, g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc);
      chk($sformatf("vec%0d_done_cycle", i), g_dn, 5);
      chk($sformatf("vec%0d_busy_cycles", i), g_busy, 5);
      chk($sformatf("vec%0d_busy_in_done", i), g_bd, 0);
      chk($sformatf("vec%0d_acc", i), g_acc, int'(tbl[i].acc));
      chk($sformatf("vec%0d_ovf", i), g_ovf, int'(tbl[i].ovf));
      @(negedge clk);
      chk($sformatf("vec%0d_done_drop", i), int'(bus.done), 0);
    end

    // Clear alone in IDLE, after first forcing overflow.
    run_op(1'b0, 4'd15, 4'd15, g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc);
    run_op(1'b0, 4'd15, 4'd15, g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc);
    chk("pre_clear_ovf", g_ovf, 1);
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    @(negedge clk);
    chk("clear_acc",  int'(bus.acc), 0);
    chk("clear_ovf",  int'(bus.overflow), 0);
    chk("clear_busy", int'(bus.busy), 0);

    // start and clear pulsed while busy are ignored; exactly one done.
    bus.start = 1'b1;
    bus.a     = 4'd2;
    bus.b     = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones     = 0;
    g_acc     = -1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b1;
        bus.clear = 1'b1;
        bus.a     = 4'd15;
        bus.b     = 4'd15;
      end else if (n == 2) begin
        bus.start = 1'b0;
        bus.clear = 1'b0;
      end
      if (bus.done) begin
        dones++;
        g_acc = int'(bus.acc);
      end
    end
    chk("busy_ignore_dones", dones, 1);
    chk("busy_ignore_acc",   g_acc, 6);
    chk("busy_ignore_final", int'(bus.acc), 6);

    // Asynchronous reset mid-MULT.
    run_op(1'b1, 4'd10, 4'd10, g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc);
    chk("pre_rst_acc", g_acc, 100);
    bus.start = 1'b1;
    bus.a     = 4'd1;
    bus.b     = 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_acc",  int'(bus.acc), 0);
    chk("async_rst_ovf",  int'(bus.overflow), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(1'b0, 4'd4, 4'd4, g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc);
    chk("post_rst_acc", g_acc, 16);
    chk("post_rst_done_cycle", g_dn, 5);

    // Exhaustive products, back-to-back starts in the done cycle.
    last_cyc = -1;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_op(1'b1, 4'(ai), 4'(bi), g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc);
        if (g_acc != ai * bi || g_ovf != 0 || g_dn != 5)
          chk($sformatf("exh_%0dx%0d", ai, bi), g_acc * 4 + g_ovf * 2 + (g_dn == 5 ? 0 : 1), ai * bi * 4);
        else
          checks++;
        if (last_cyc >= 0) begin
          if (g_cyc - last_cyc != 6) chk($sformatf("period_%0dx%0d", ai, bi), g_cyc - last_cyc, 6);
          else checks++;
        end
        last_cyc = g_cyc;
      end
    end

    // Random operations against a plain-arithmetic accumulator model.
    acc_m = 0;
    ovf_m = 0;
    for (int i = 0; i < 60; i++) begin
      rclr = (i == 0) || ($urandom_range(0, 4) == 0);
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      if (rclr) begin
        acc_m = 0;
        ovf_m = 0;
      end
      s     = acc_m + int'(ra) * int'(rb);
      ovf_m = ovf_m | ((s > 255) ? 1 : 0);
      acc_m = s % 256;
      run_op(rclr, ra, rb, g_acc, g_ovf, g_busy, g_dn, g_bd, g_cyc);
      chk($sformatf("rnd%0d_acc", i), g_acc, acc_m);
      chk($sformatf("rnd%0d_ovf", i), g_ovf, ovf_m);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
